// File: rtl/tx_ctrl_pkg.sv
`default_nettype none
// =====================================================================
// Package : tx_ctrl_pkg
// Shared source/state encodings, gain limits and the tone table.
// Rev     : 1.0
// =====================================================================
package tx_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_TONE    = 2'd0,
    SRC_EXT     = 2'd1,
    SRC_SILENCE = 2'd2
  } src_e;

  localparam logic [1:0] ST_MUTE     = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  localparam int GAIN_W   = 4;
  localparam int GAIN_MAX = 16;
  localparam int TONE_LEN = 20;

  // One full cycle of the test tone, signed 16-bit
  localparam logic [15:0] TONE_ROM [TONE_LEN] = '{
    16'h0000, 16'h278E, 16'h4B3C, 16'h678D, 16'h79BB,
    16'h7FFF, 16'h79BB, 16'h678D, 16'h4B3C, 16'h278E,
    16'h0000, 16'hD872, 16'hB4C4, 16'h9873, 16'h8645,
    16'h8001, 16'h8645, 16'h9873, 16'hB4C4, 16'hD872
  };

endpackage
`default_nettype wire

// File: rtl/tx_sample_fifo.sv
`default_nettype none
// =====================================================================
// Module : tx_sample_fifo
// Small synchronous FIFO for external samples, with a hold-empty flush.
// Rev    : 1.0
// =====================================================================
module tx_sample_fifo #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_q];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tx_source_scheduler.sv
`default_nettype none
// =====================================================================
// Module : tx_source_scheduler
// Sample-strobe divider, source select and 16-step fade for the FM TX.
// Rev    : 1.0
// =====================================================================
module tx_source_scheduler
  import tx_ctrl_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIV_W      = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int UNDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        src_sel,
  input  logic [DIV_W-1:0]  stb_rate,
  input  logic [WIDTH-1:0]  ext_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  output logic [WIDTH-1:0]  data_out,
  output logic              stb_out,
  output logic [1:0]        state_o,
  output logic [1:0]        active_src,
  output logic [UNDR_W-1:0] underrun_cnt
);
  localparam logic [GAIN_W:0] GAIN_FULL  = (GAIN_W+1)'(GAIN_MAX);
  localparam logic [4:0]      PHASE_LAST = 5'(TONE_LEN - 1);

  logic [DIV_W-1:0]  cnt_q, cnt_d, div_last;
  logic [1:0]        state_q, state_d;
  logic [GAIN_W:0]   gain_q, gain_d;
  src_e              src_q, src_d;
  logic [4:0]        phase_q, phase_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              stb_q, stb_d;
  logic [UNDR_W-1:0] undr_q, undr_d;

  logic run, tick, change;
  logic fifo_full, fifo_empty, fifo_flush, fifo_push, fifo_pop;
  logic [WIDTH-1:0] fifo_dout;
  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH+4:0] sample_x, gain_x, prod;

  assign ext_ready  = !fifo_full && (src_q == SRC_EXT);
  assign fifo_flush = (src_q != SRC_EXT);
  assign fifo_push  = ext_valid && ext_ready;
  assign fifo_pop   = tick && (src_q == SRC_EXT);

  tx_sample_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (ext_data),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Rates below 2 are clamped so the strobe never runs every cycle
  always_comb begin
    div_last = ((stb_rate < DIV_W'(2)) ? DIV_W'(2) : stb_rate) - DIV_W'(1);
    run      = enable || (state_q != ST_MUTE);
    tick     = run && (cnt_q == div_last);
    cnt_d    = '0;
    if (run && !tick) cnt_d = cnt_q + DIV_W'(1);
  end

  always_comb begin
    sample = '0;
    case (src_q)
      SRC_TONE: sample = WIDTH'($signed(TONE_ROM[phase_q]));
      SRC_EXT:  sample = fifo_empty ? '0 : $signed(fifo_dout);
      default:  sample = '0;
    endcase
    sample_x = {{5{sample[WIDTH-1]}}, sample};
    gain_x   = {{WIDTH{1'b0}}, gain_q};
    prod     = sample_x * gain_x;
    data_d   = tick ? WIDTH'(prod >>> 4) : data_q;
    stb_d    = tick;
    undr_d   = undr_q;
    if (fifo_pop && fifo_empty && (undr_q != '1)) undr_d = undr_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    src_d   = src_q;
    phase_d = phase_q;
    change  = !enable || (src_sel != src_q);
    if (tick) begin
      if (src_q == SRC_TONE) phase_d = (phase_q == PHASE_LAST) ? 5'd0 : phase_q + 5'd1;
      case (state_q)
        ST_MUTE: begin
          if (enable && ((src_sel == SRC_TONE) || (src_sel == SRC_EXT))) begin
            src_d   = src_e'(src_sel);
            phase_d = '0;
            state_d = ST_FADE_IN;
          end
        end
        ST_FADE_IN: begin
          if (change) begin
            state_d = ST_FADE_OUT;
          end else begin
            gain_d = gain_q + 1'b1;
            if (gain_d == GAIN_FULL) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (change) state_d = ST_FADE_OUT;
        end
        default: begin
          // A fade-out that starts at gain 0 must not wrap the gain
          if (gain_q <= (GAIN_W+1)'(1)) begin
            gain_d  = '0;
            state_d = ST_MUTE;
            src_d   = SRC_SILENCE;
          end else begin
            gain_d = gain_q - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= ST_MUTE;
      gain_q  <= '0;
      src_q   <= SRC_SILENCE;
      phase_q <= '0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      undr_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      gain_q  <= gain_d;
      src_q   <= src_d;
      phase_q <= phase_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      undr_q  <= undr_d;
    end
  end

  assign data_out     = data_q;
  assign stb_out      = stb_q;
  assign state_o      = state_q;
  assign active_src   = src_q;
  assign underrun_cnt = undr_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_source_scheduler.sv
`default_nettype none
// =====================================================================
// Module : tb_tx_source_scheduler
// Directed scenarios with hand-derived expectations for the scheduler.
// Rev    : 1.0
// =====================================================================
module tb_tx_source_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  src_sel = 2'd2;
  logic [13:0] stb_rate = 14'd10;
  logic [15:0] ext_data = 16'h0000;
  logic        ext_valid = 1'b0;
  logic        ext_ready;
  logic [15:0] data_out;
  logic        stb_out;
  logic [1:0]  state_o;
  logic [1:0]  active_src;
  logic [7:0]  underrun_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  logic signed [15:0] rom [20] = '{
    16'h0000, 16'h278E, 16'h4B3C, 16'h678D, 16'h79BB,
    16'h7FFF, 16'h79BB, 16'h678D, 16'h4B3C, 16'h278E,
    16'h0000, 16'hD872, 16'hB4C4, 16'h9873, 16'h8645,
    16'h8001, 16'h8645, 16'h9873, 16'hB4C4, 16'hD872
  };

  always #5 clk = ~clk;

  tx_source_scheduler #(
    .WIDTH(16), .DIV_W(14), .FIFO_DEPTH(4), .UNDR_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .src_sel      (src_sel),
    .stb_rate     (stb_rate),
    .ext_data     (ext_data),
    .ext_valid    (ext_valid),
    .ext_ready    (ext_ready),
    .data_out     (data_out),
    .stb_out      (stb_out),
    .state_o      (state_o),
    .active_src   (active_src),
    .underrun_cnt (underrun_cnt)
  );

  function automatic logic [15:0] scale(input logic signed [15:0] s, input int g);
    int p;
    p = int'(s) * g;
    return 16'(p >>> 4);
  endfunction

  // Strobe 1 is the mute-exit tick (silence); strobe j>=2 is phase j-2 at gain j-2
  function automatic logic [15:0] tone_exp(input int j);
    int k;
    if (j < 2) return 16'h0000;
    k = j - 2;
    return scale(rom[k % 20], (k > 16) ? 16 : k);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; src_sel = 2'd2; stb_rate = 14'd10;
    ext_valid = 1'b0; ext_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Cycles until the next stb_out (-1 on timeout); held=0 if data_out moved meanwhile
  task automatic wait_strobe(input int limit, output int n, output bit held);
    logic [15:0] d0;
    d0 = data_out;
    held = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (stb_out) begin n = i; return; end
      if (data_out !== d0) held = 1'b0;
    end
    n = -1;
  endtask

  task automatic test_reset();
    int stbs = 0, bad = 0;
    apply_reset();
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_cmp++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0000", data_out); end
    n_cmp++; if (stb_out !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b want 0", stb_out); end
    n_cmp++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", ext_ready); end
    n_cmp++; if (active_src !== 2'd2) begin n_fail++; $display("FAIL rst_src: got %0d want 2", active_src); end
    n_cmp++; if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_undr: got %0d want 0", underrun_cnt); end
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (stb_out) stbs++;
      if (data_out !== 16'h0 || ext_ready !== 1'b0 || state_o !== 2'd0) bad++;
    end
    n_cmp++; if (stbs !== 0) begin n_fail++; $display("FAIL idle_strobes: got %0d want 0", stbs); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL idle_outputs: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_tone_fade_in();
    int n, bad_hold = 0;
    bit held;
    apply_reset();
    enable = 1'b1; src_sel = 2'd0; stb_rate = 14'd10;
    for (int j = 1; j <= 25; j++) begin
      wait_strobe(40, n, held);
      if (!held) bad_hold++;
      n_cmp++; if (n !== 10) begin n_fail++; $display("FAIL tone_interval[%0d]: got %0d want 10", j, n); end
      n_cmp++; if (data_out !== tone_exp(j)) begin n_fail++; $display("FAIL tone_data[%0d]: got %h want %h", j, data_out, tone_exp(j)); end
      n_cmp++; if (state_o !== ((j >= 17) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL tone_state[%0d]: got %0d", j, state_o); end
      if (j == 7) begin
        n_cmp++; if (data_out !== 16'h27FF) begin n_fail++; $display("FAIL tone_gain5_peak: got %h want 27ff", data_out); end
      end
    end
    n_cmp++; if (bad_hold !== 0) begin n_fail++; $display("FAIL tone_hold: got %0d changes want 0", bad_hold); end
  endtask

  task automatic test_underrun();
    int n, bad_int = 0, bad_data = 0;
    bit held;
    apply_reset();
    enable = 1'b1; src_sel = 2'd1; stb_rate = 14'd10;
    for (int j = 1; j <= 5; j++) begin
      wait_strobe(40, n, held);
      if (n !== 10) bad_int++;
      if (data_out !== 16'h0) bad_data++;
    end
    n_cmp++; if (underrun_cnt !== 8'd4) begin n_fail++; $display("FAIL undr_after5: got %0d want 4", underrun_cnt); end
    n_cmp++; if (active_src !== 2'd1) begin n_fail++; $display("FAIL undr_src: got %0d want 1", active_src); end
    n_cmp++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL undr_ready: got %b want 1", ext_ready); end
    stb_rate = 14'd1;
    for (int j = 6; j <= 300; j++) begin
      wait_strobe(10, n, held);
      if (n !== 2) bad_int++;
      if (data_out !== 16'h0) bad_data++;
      if (j == 100) begin
        n_cmp++; if (underrun_cnt !== 8'd99) begin n_fail++; $display("FAIL undr_after100: got %0d want 99", underrun_cnt); end
      end
    end
    n_cmp++; if (underrun_cnt !== 8'd255) begin n_fail++; $display("FAIL undr_saturate: got %0d want 255", underrun_cnt); end
    n_cmp++; if (bad_int !== 0) begin n_fail++; $display("FAIL undr_interval: got %0d bad want 0", bad_int); end
    n_cmp++; if (bad_data !== 0) begin n_fail++; $display("FAIL undr_data: got %0d nonzero want 0", bad_data); end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [6] = '{16'h1234, 16'h2000, 16'hF001, 16'h7FFF, 16'h5555, 16'h6666};
    logic [15:0] want [4] = '{16'h0200, 16'hFE00, 16'h17FF, 16'h0000};
    int n, acc = 0;
    bit held;
    apply_reset();
    enable = 1'b1; src_sel = 2'd1; stb_rate = 14'd40;
    wait_strobe(60, n, held);
    n_cmp++; if (n !== 40) begin n_fail++; $display("FAIL bp_first: got %0d want 40", n); end
    for (int i = 0; i < 6; i++) begin
      ext_valid = 1'b1; ext_data = vals[i];
      if (ext_ready) acc++;
      @(posedge clk); #1;
    end
    ext_valid = 1'b0;
    n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_cmp++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", ext_ready); end
    wait_strobe(60, n, held);
    n_cmp++; if (n !== 34) begin n_fail++; $display("FAIL bp_pop_tick: got %0d want 34", n); end
    n_cmp++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL bp_gain0: got %h want 0000", data_out); end
    n_cmp++; if (ext_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", ext_ready); end
    for (int k = 0; k < 4; k++) begin
      wait_strobe(60, n, held);
      n_cmp++; if (data_out !== want[k]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, data_out, want[k]); end
      n_cmp++; if (underrun_cnt !== ((k == 3) ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL bp_undr[%0d]: got %0d", k, underrun_cnt); end
    end
  endtask

  task automatic test_switch();
    int n, g, bad_int = 0;
    bit held;
    logic [15:0] e;
    apply_reset();
    enable = 1'b1; src_sel = 2'd0; stb_rate = 14'd4;
    ext_valid = 1'b1; ext_data = 16'h4000;
    for (int j = 1; j <= 54; j++) begin
      wait_strobe(20, n, held);
      if (n !== 4) bad_int++;
      if (j <= 19)      e = tone_exp(j);
      else if (j <= 35) e = scale(rom[(j - 2) % 20], 36 - j);
      else if (j == 36) e = 16'h0000;
      else begin
        g = (j - 37 > 16) ? 16 : j - 37;
        e = scale(16'sh4000, g);
      end
      n_cmp++; if (data_out !== e) begin n_fail++; $display("FAIL sw_data[%0d]: got %h want %h", j, data_out, e); end
      if (j == 18) begin
        n_cmp++; if (ext_ready !== 1'b0) begin n_fail++; $display("FAIL sw_ready_tone: got %b want 0", ext_ready); end
        src_sel = 2'd1;
      end
      if (j == 19) begin
        n_cmp++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL sw_fadeout: got %0d want 3", state_o); end
      end
      if (j == 35) begin
        n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL sw_mute: got %0d want 0", state_o); end
        n_cmp++; if (active_src !== 2'd2) begin n_fail++; $display("FAIL sw_mute_src: got %0d want 2", active_src); end
      end
      if (j == 36) begin
        n_cmp++; if (active_src !== 2'd1) begin n_fail++; $display("FAIL sw_ext_src: got %0d want 1", active_src); end
      end
    end
    ext_valid = 1'b0;
    n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL sw_run: got %0d want 2", state_o); end
    n_cmp++; if (underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL sw_undr: got %0d want 0", underrun_cnt); end
    n_cmp++; if (bad_int !== 0) begin n_fail++; $display("FAIL sw_interval: got %0d bad want 0", bad_int); end
  endtask

  task automatic test_reset_mid_fade();
    int n;
    bit held;
    apply_reset();
    enable = 1'b1; src_sel = 2'd0; stb_rate = 14'd10;
    for (int j = 1; j <= 8; j++) wait_strobe(40, n, held);
    n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL mid_pre_state: got %0d want 1", state_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", state_o); end
    n_cmp++; if (data_out !== 16'h0) begin n_fail++; $display("FAIL mid_data: got %h want 0000", data_out); end
    n_cmp++; if (stb_out !== 1'b0) begin n_fail++; $display("FAIL mid_stb: got %b want 0", stb_out); end
    n_cmp++; if (active_src !== 2'd2) begin n_fail++; $display("FAIL mid_src: got %0d want 2", active_src); end
    n_cmp++; if (ext_ready !== 1'b0 || underrun_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_misc: got %b/%0d want 0/0", ext_ready, underrun_cnt); end
    rst_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      wait_strobe(40, n, held);
      n_cmp++; if (n !== 10) begin n_fail++; $display("FAIL mid_interval[%0d]: got %0d want 10", j, n); end
      n_cmp++; if (data_out !== tone_exp(j)) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want %h", j, data_out, tone_exp(j)); end
    end
  endtask

  initial begin
    test_reset();
    test_tone_fade_in();
    test_underrun();
    test_backpressure();
    test_switch();
    test_reset_mid_fade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
